// File: rtl/nibbler_pkg.sv
// Shared types and constants for the Nibbler accumulator core.
// Provides opcode_t, state_t and instruction field positions.
package nibbler_pkg;

    localparam int INSTR_W = 16;
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_LIT  = 4'h1,
        OP_ADD  = 4'h2,
        OP_SUB  = 4'h3,
        OP_NAND = 4'h4,
        OP_CMP  = 4'h5,
        OP_IN   = 4'h6,
        OP_OUT  = 4'h7,
        OP_JMP  = 4'h8,
        OP_JC   = 4'h9,
        OP_JNC  = 4'hA,
        OP_JZ   = 4'hB,
        OP_JNZ  = 4'hC,
        OP_CALL = 4'hD,
        OP_RET  = 4'hE,
        OP_HALT = 4'hF
    } opcode_t;

    typedef enum logic [1:0] {
        FETCH,
        EXEC,
        WAIT_IN,
        HALT
    } state_t;

endpackage

// File: rtl/nibbler_if.sv
// Board-side bus of the Nibbler core: ROM fetch port and I/O ports.
// master = core (drives imem_addr, in_ack, out_*); slave = board.
interface nibbler_if
    import nibbler_pkg::*;
#(
    parameter int N       = 4,
    parameter int NUM_IN  = 3,
    parameter int NUM_OUT = 3,
    parameter int PC_W    = 12
);
    logic [PC_W-1:0]      imem_addr;
    logic [INSTR_W-1:0]   imem_data;
    logic [NUM_IN*N-1:0]  in_data;
    logic [NUM_IN-1:0]    in_valid;
    logic [NUM_IN-1:0]    in_ack;
    logic [NUM_OUT*N-1:0] out_data;
    logic [NUM_OUT-1:0]   out_strobe;

    modport master (
        output imem_addr,
        input  imem_data,
        input  in_data,
        input  in_valid,
        output in_ack,
        output out_data,
        output out_strobe
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        output in_data,
        output in_valid,
        input  in_ack,
        input  out_data,
        input  out_strobe
    );
endinterface

// File: rtl/nibbler_call_stack.sv
// Return-address LIFO for CALL/RET.
// Ports: clk, reset, push/pop + din, top (last pushed), full, empty.
module nibbler_call_stack #(
    parameter int W     = 12,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] top,
    output logic         full,
    output logic         empty
);
    localparam int SP_W = $clog2(DEPTH + 1);
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]    mem [DEPTH];
    logic [SP_W-1:0] sp;
    logic [SP_W-1:0] sp_dec;
    logic [AW-1:0]   wr_idx;
    logic [AW-1:0]   rd_idx;

    assign sp_dec = sp - SP_W'(1);
    assign wr_idx = AW'(sp);
    assign rd_idx = AW'(sp_dec);
    assign top    = mem[rd_idx];
    assign full   = (sp == SP_W'(DEPTH));
    assign empty  = (sp == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp <= '0;
        end else if (push && !full) begin
            sp <= sp + SP_W'(1);
        end else if (pop && !empty) begin
            sp <= sp_dec;
        end
    end

    // Storage needs no reset: sp gates every read.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_idx] <= din;
        end
    end
endmodule

// File: rtl/nibbler_core.sv
// Nibbler accumulator CPU: 2-cycle fetch/execute, C/Z flags, I/O, call stack.
// Ports: clk, reset, bus (ROM + I/O), accu, c_flag, z_flag, instr, halted, fault.
module nibbler_core
    import nibbler_pkg::*;
#(
    parameter int N           = 4,
    parameter int NUM_IN      = 3,
    parameter int NUM_OUT     = 3,
    parameter int PC_W        = 12,
    parameter int STACK_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    nibbler_if.master          bus,
    output logic [N-1:0]       accu,
    output logic               c_flag,
    output logic               z_flag,
    output logic [INSTR_W-1:0] instr,
    output logic               halted,
    output logic               fault
);
    state_t               state;
    opcode_t              op;
    logic [PC_W-1:0]      pc;
    logic [PC_W-1:0]      pc_inc;
    logic [PC_W-1:0]      addr;
    logic [PC_W-1:0]      top;
    logic [N-1:0]         imm;
    logic [N-1:0]         nand_r;
    logic [N-1:0]         sel_word;
    logic [N:0]           sum;
    logic [N:0]           diff;
    logic [3:0]           port;
    logic [NUM_IN-1:0]    in_hit;
    logic [NUM_IN-1:0]    ack_q;
    logic [NUM_OUT-1:0]   out_hit;
    logic [NUM_OUT-1:0]   strobe_q;
    logic [NUM_OUT*N-1:0] out_q;
    logic                 in_ok;
    logic                 sel_valid;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;

    assign bus.imem_addr  = pc;
    assign bus.in_ack     = ack_q;
    assign bus.out_data   = out_q;
    assign bus.out_strobe = strobe_q;

    assign op     = opcode_t'(bus.imem_data[OPC_MSB:OPC_LSB]);
    assign imm    = bus.imem_data[N-1:0];
    assign addr   = bus.imem_data[PC_W-1:0];
    assign pc_inc = pc + PC_W'(1);
    assign sum    = {1'b0, accu} + {1'b0, imm};
    assign diff   = {1'b0, accu} - {1'b0, imm};
    assign nand_r = ~(accu & imm);

    // While waiting for input the ROM word is gone; use the latched copy.
    assign port = (state == EXEC) ? bus.imem_data[3:0] : instr[3:0];

    always_comb begin
        in_hit   = '0;
        sel_word = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            in_hit[i] = (port == 4'(i));
            if (port == 4'(i)) sel_word = bus.in_data[i*N +: N];
        end
        out_hit = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            out_hit[i] = (port == 4'(i));
        end
    end

    assign in_ok     = |in_hit;
    assign sel_valid = |(in_hit & bus.in_valid);
    assign push      = (state == EXEC) && (op == OP_CALL) && !full;
    assign pop       = (state == EXEC) && (op == OP_RET) && !empty;

    nibbler_call_stack #(
        .W     (PC_W),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (pc_inc),
        .top   (top),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= FETCH;
            pc       <= '0;
            accu     <= '0;
            c_flag   <= 1'b0;
            z_flag   <= 1'b0;
            instr    <= '0;
            halted   <= 1'b0;
            fault    <= 1'b0;
            out_q    <= '0;
            ack_q    <= '0;
            strobe_q <= '0;
        end else begin
            ack_q    <= '0;
            strobe_q <= '0;
            unique case (state)
                FETCH: state <= EXEC;
                EXEC: begin
                    instr <= bus.imem_data;
                    pc    <= pc_inc;
                    state <= FETCH;
                    unique case (op)
                        OP_NOP: ;
                        OP_LIT: begin
                            accu   <= imm;
                            z_flag <= (imm == '0);
                        end
                        OP_ADD: begin
                            {c_flag, accu} <= sum;
                            z_flag <= (sum[N-1:0] == '0);
                        end
                        OP_SUB: begin
                            accu   <= diff[N-1:0];
                            c_flag <= diff[N];
                            z_flag <= (diff[N-1:0] == '0);
                        end
                        OP_NAND: begin
                            accu   <= nand_r;
                            z_flag <= (nand_r == '0);
                        end
                        OP_CMP: begin
                            c_flag <= diff[N];
                            z_flag <= (diff[N-1:0] == '0);
                        end
                        OP_IN: begin
                            if (!in_ok) begin
                                accu   <= '0;
                                z_flag <= 1'b1;
                            end else if (sel_valid) begin
                                accu   <= sel_word;
                                z_flag <= (sel_word == '0);
                                ack_q  <= in_hit;
                            end else begin
                                state <= WAIT_IN;
                            end
                        end
                        OP_OUT: begin
                            for (int i = 0; i < NUM_OUT; i++) begin
                                if (out_hit[i]) out_q[i*N +: N] <= accu;
                            end
                            strobe_q <= out_hit;
                        end
                        OP_JMP: pc <= addr;
                        OP_JC:  if (c_flag) pc <= addr;
                        OP_JNC: if (!c_flag) pc <= addr;
                        OP_JZ:  if (z_flag) pc <= addr;
                        OP_JNZ: if (!z_flag) pc <= addr;
                        OP_CALL: begin
                            if (full) begin
                                pc     <= pc;
                                fault  <= 1'b1;
                                halted <= 1'b1;
                                state  <= HALT;
                            end else begin
                                pc <= addr;
                            end
                        end
                        OP_RET: begin
                            if (empty) begin
                                pc     <= pc;
                                fault  <= 1'b1;
                                halted <= 1'b1;
                                state  <= HALT;
                            end else begin
                                pc <= top;
                            end
                        end
                        OP_HALT: begin
                            halted <= 1'b1;
                            state  <= HALT;
                        end
                    endcase
                end
                WAIT_IN: begin
                    if (sel_valid) begin
                        accu   <= sel_word;
                        z_flag <= (sel_word == '0);
                        ack_q  <= in_hit;
                        state  <= FETCH;
                    end
                end
                HALT: ;
            endcase
        end
    end
endmodule
